// File: rtl/pipe_ctrl.sv
// Pipeline control FSM: sequences BOOT/RUN/MEMWAIT/HALT and drives per-stage enables and flushes.
// Optional performance counters are built when PIPE_CTRL_PERF_CNT_EN is defined.
module pipe_ctrl (
  input  logic        clk,
  input  logic        rstn,
  input  logic        hz_stall,
  input  logic        br_taken,
  input  logic        dmem_req,
  input  logic        dmem_ready,
  input  logic        halt_req,
  input  logic        resume,
  input  logic        perf_clr,
  output logic        PC_we,
  output logic        IF_ID_we,
  output logic        IF_ID_flush,
  output logic        ID_EX_we,
  output logic        ID_EX_flush,
  output logic        EX_MEM_we,
  output logic        MEM_WB_flush,
  output logic        halted,
  output logic [1:0]  state,
  output logic [31:0] cyc_cnt,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  typedef enum logic [1:0] {
    StBoot    = 2'd0,
    StRun     = 2'd1,
    StMemWait = 2'd2,
    StHalt    = 2'd3
  } state_e;

  // Bit order: PC_we, IF_ID_we, IF_ID_flush, ID_EX_we, ID_EX_flush, EX_MEM_we, MEM_WB_flush
  localparam logic [6:0] PatBoot     = 7'b0010101;
  localparam logic [6:0] PatFreeze   = 7'b0000001;
  localparam logic [6:0] PatLoadUse  = 7'b0001110;
  localparam logic [6:0] PatRedirect = 7'b1111010;
  localparam logic [6:0] PatNormal   = 7'b1101010;

  state_e     state_q, state_d;
  logic [6:0] pat;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StBoot;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pat     = PatFreeze;
    unique case (state_q)
      StBoot: begin
        pat     = PatBoot;
        state_d = StRun;
      end
      StRun: begin
        if (halt_req) begin
          pat     = PatFreeze;
          state_d = StHalt;
        end else if (dmem_req && !dmem_ready) begin
          pat     = PatFreeze;
          state_d = StMemWait;
        end else if (hz_stall) begin
          pat = PatLoadUse;
        end else if (br_taken) begin
          pat = PatRedirect;
        end else begin
          pat = PatNormal;
        end
      end
      StMemWait: begin
        // halt_req and resume are deliberately not looked at while memory is outstanding
        if (!dmem_ready) begin
          pat = PatFreeze;
        end else begin
          state_d = StRun;
          if (hz_stall) begin
            pat = PatLoadUse;
          end else if (br_taken) begin
            pat = PatRedirect;
          end else begin
            pat = PatNormal;
          end
        end
      end
      StHalt: begin
        pat = PatFreeze;
        if (resume) begin
          state_d = StRun;
        end
      end
      default: begin
        pat     = PatBoot;
        state_d = StBoot;
      end
    endcase
  end

  assign {PC_we, IF_ID_we, IF_ID_flush, ID_EX_we, ID_EX_flush, EX_MEM_we, MEM_WB_flush} = pat;
  assign halted = (state_q == StHalt);
  assign state  = state_q;

`ifdef PIPE_CTRL_PERF_CNT_EN
  logic [31:0] cyc_cnt_q, cyc_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;
  logic        in_pipe;

  assign in_pipe = (state_q == StRun) || (state_q == StMemWait);

  always_comb begin
    cyc_cnt_d   = cyc_cnt_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (perf_clr) begin
      cyc_cnt_d   = '0;
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (state_q != StBoot) cyc_cnt_d = cyc_cnt_q + 32'd1;
      if (in_pipe && !PC_we) stall_cnt_d = stall_cnt_q + 32'd1;
      if (in_pipe && IF_ID_flush) flush_cnt_d = flush_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cyc_cnt_q   <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      cyc_cnt_q   <= cyc_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign cyc_cnt   = cyc_cnt_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  logic unused_perf_clr;
  assign unused_perf_clr = perf_clr;
  assign cyc_cnt   = '0;
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl; counter expectations follow PIPE_CTRL_PERF_CNT_EN.
module tb_pipe_ctrl;

`ifdef PIPE_CTRL_PERF_CNT_EN
  localparam bit Perf = 1'b1;
`else
  localparam bit Perf = 1'b0;
`endif

  localparam logic [6:0] PatBoot     = 7'b0010101;
  localparam logic [6:0] PatFreeze   = 7'b0000001;
  localparam logic [6:0] PatLoadUse  = 7'b0001110;
  localparam logic [6:0] PatRedirect = 7'b1111010;
  localparam logic [6:0] PatNormal   = 7'b1101010;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic hz_stall = 1'b0, br_taken = 1'b0, dmem_req = 1'b0, dmem_ready = 1'b0;
  logic halt_req = 1'b0, resume = 1'b0, perf_clr = 1'b0;
  logic PC_we, IF_ID_we, IF_ID_flush, ID_EX_we, ID_EX_flush, EX_MEM_we, MEM_WB_flush, halted;
  logic [1:0]  state;
  logic [31:0] cyc_cnt, stall_cnt, flush_cnt;
  logic [6:0]  pat;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_ctrl dut (
    .clk          (clk),
    .rstn         (rstn),
    .hz_stall     (hz_stall),
    .br_taken     (br_taken),
    .dmem_req     (dmem_req),
    .dmem_ready   (dmem_ready),
    .halt_req     (halt_req),
    .resume       (resume),
    .perf_clr     (perf_clr),
    .PC_we        (PC_we),
    .IF_ID_we     (IF_ID_we),
    .IF_ID_flush  (IF_ID_flush),
    .ID_EX_we     (ID_EX_we),
    .ID_EX_flush  (ID_EX_flush),
    .EX_MEM_we    (EX_MEM_we),
    .MEM_WB_flush (MEM_WB_flush),
    .halted       (halted),
    .state        (state),
    .cyc_cnt      (cyc_cnt),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  assign pat = {PC_we, IF_ID_we, IF_ID_flush, ID_EX_we, ID_EX_flush, EX_MEM_we, MEM_WB_flush};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Apply inputs mid-cycle so the combinational outputs settle well away from the edge.
  task automatic drive(input logic hz, input logic br, input logic dreq, input logic drdy,
                       input logic hlt, input logic res, input logic clr);
    @(negedge clk);
    hz_stall   = hz;
    br_taken   = br;
    dmem_req   = dreq;
    dmem_ready = drdy;
    halt_req   = hlt;
    resume     = res;
    perf_clr   = clr;
    #1;
  endtask

  task automatic check_cnt(input string tag, input int cyc, input int stl, input int fl);
    check({tag, "_cyc"}, cyc_cnt, Perf ? 32'(cyc) : 32'd0);
    check({tag, "_stall"}, stall_cnt, Perf ? 32'(stl) : 32'd0);
    check({tag, "_flush"}, flush_cnt, Perf ? 32'(fl) : 32'd0);
  endtask

  initial begin
    #3;
    check("rst_state", 32'(state), 32'd0);
    check("rst_pat", 32'(pat), 32'(PatBoot));
    check("rst_halted", 32'(halted), 32'd0);
    check_cnt("rst", 0, 0, 0);

    @(negedge clk);
    rstn = 1'b1;
    #1;
    check("boot_state", 32'(state), 32'd0);
    check("boot_pat", 32'(pat), 32'(PatBoot));

    drive(0, 0, 0, 0, 0, 0, 0);
    check("run_state", 32'(state), 32'd1);
    check("run_normal", 32'(pat), 32'(PatNormal));
    check_cnt("after_boot", 0, 0, 0);

    drive(1, 1, 0, 0, 0, 0, 0);
    check("loaduse_pat", 32'(pat), 32'(PatLoadUse));
    drive(0, 1, 0, 0, 0, 0, 0);
    check("redirect_pat", 32'(pat), 32'(PatRedirect));
    drive(0, 0, 0, 0, 0, 0, 0);
    check("post_redirect_pat", 32'(pat), 32'(PatNormal));

    drive(0, 0, 1, 0, 0, 0, 0);
    check("memreq_state", 32'(state), 32'd1);
    check("memreq_pat", 32'(pat), 32'(PatFreeze));
    check_cnt("pre_mem", 4, 1, 1);
    drive(0, 0, 1, 0, 1, 0, 0);
    check("memwait_state", 32'(state), 32'd2);
    check("memwait_halt_pat", 32'(pat), 32'(PatFreeze));
    check("memwait_halted", 32'(halted), 32'd0);
    drive(0, 0, 1, 0, 0, 0, 0);
    check("memwait_hold", 32'(state), 32'd2);
    check("memwait_pat", 32'(pat), 32'(PatFreeze));
    drive(1, 0, 1, 1, 0, 0, 0);
    check("memdone_state", 32'(state), 32'd2);
    check("memdone_loaduse", 32'(pat), 32'(PatLoadUse));
    check_cnt("mem_freeze", 7, 4, 1);

    drive(0, 0, 0, 0, 1, 0, 0);
    check("halt_req_state", 32'(state), 32'd1);
    check("halt_req_pat", 32'(pat), 32'(PatFreeze));
    drive(0, 0, 0, 0, 0, 0, 0);
    check("halt_state", 32'(state), 32'd3);
    check("halt_halted", 32'(halted), 32'd1);
    check("halt_pat", 32'(pat), 32'(PatFreeze));
    drive(0, 0, 0, 0, 0, 1, 0);
    check("resume_state", 32'(state), 32'd3);
    drive(0, 0, 0, 0, 0, 0, 0);
    check("resumed_state", 32'(state), 32'd1);
    check("resumed_halted", 32'(halted), 32'd0);
    check("resumed_pat", 32'(pat), 32'(PatNormal));
    check_cnt("post_halt", 11, 6, 1);

    drive(0, 0, 0, 1, 0, 0, 0);
    check("ready_only_pat", 32'(pat), 32'(PatNormal));
    drive(1, 0, 0, 0, 0, 0, 1);
    check("clr_pat", 32'(pat), 32'(PatLoadUse));
    drive(0, 0, 0, 0, 0, 0, 0);
    check("clr_state", 32'(state), 32'd1);
    check_cnt("clr", 0, 0, 0);

`ifdef PIPE_CTRL_PERF_CNT_EN
    force dut.cyc_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.cyc_cnt_q;
`endif
    drive(0, 0, 1, 0, 0, 0, 0);
    check("wrap_cyc", cyc_cnt, 32'd0);
    drive(0, 0, 1, 0, 0, 0, 0);
    check("mw2_state", 32'(state), 32'd2);
    #2;
    rstn = 1'b0;
    #1;
    check("async_rst_state", 32'(state), 32'd0);
    check("async_rst_pat", 32'(pat), 32'(PatBoot));
    check("async_rst_halted", 32'(halted), 32'd0);
    check_cnt("async_rst", 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    rstn = 1'b1;
    #1;
    check("reboot_state", 32'(state), 32'd0);
    check("reboot_pat", 32'(pat), 32'(PatBoot));
    drive(0, 0, 0, 0, 0, 0, 0);
    check("rerun_state", 32'(state), 32'd1);
    check("rerun_pat", 32'(pat), 32'(PatNormal));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk  in  1  rising-edge clock; rstn  in  1  asynchronous active-low reset.
REQ-002 The block SHALL have these control inputs:
- hz_stall  in  1  load-use / branch-operand stall from the hazard detector.
- br_taken  in  1  ID-stage branch/jump resolved taken.
- dmem_req  in  1  MEM-stage load/store valid.
- dmem_ready  in  1  data memory acknowledge.
- halt_req  in  1  ebreak/ecall retiring in WB.
- resume  in  1  single-cycle pulse that leaves HALT.
- perf_clr  in  1  synchronous clear of the counters.
REQ-003 The block SHALL have these pipeline-control outputs, all 1 bit:
- PC_we  out  1  PC load enable.
- IF_ID_we  out  1  IF/ID write enable.
- IF_ID_flush  out  1  IF/ID load NOP.
- ID_EX_we  out  1  ID/EX write enable.
- ID_EX_flush  out  1  ID/EX load bubble.
- EX_MEM_we  out  1  EX/MEM write enable.
- MEM_WB_flush  out  1  MEM/WB load bubble.
- halted  out  1  state==HALT.
REQ-004 The block SHALL have these status outputs: state  out  2  current state; cyc_cnt, stall_cnt, flush_cnt  out  32 each  performance counters.

Function
REQ-005 States SHALL be BOOT=0, RUN=1, MEMWAIT=2, HALT=3, held in a register; every pipeline-control output SHALL be combinational from state and the current inputs, with no added latency.
REQ-006 A flush SHALL override the write enable of the same pipeline register (flush=1 means load NOP regardless of we).
REQ-007 Output patterns (PC_we, IF_ID_we, IF_ID_flush, ID_EX_we, ID_EX_flush, EX_MEM_we, MEM_WB_flush) SHALL be:
- BOOT = 0,0,1,0,1,0,1.
- FREEZE = 0,0,0,0,0,0,1.
- LOADUSE = 0,0,0,1,1,1,0.
- REDIRECT = 1,1,1,1,0,1,0.
- NORMAL = 1,1,0,1,0,1,0.
REQ-008 BOOT SHALL drive BOOT for exactly one cycle and then go to RUN unconditionally.
REQ-009 In RUN, fixed priority SHALL be halt_req > (dmem_req && !dmem_ready) > hz_stall > br_taken > none.
REQ-010 In RUN, halt_req=1 SHALL drive FREEZE, and next state SHALL be HALT.
REQ-011 In RUN with dmem_req=1 and dmem_ready=0 (halt_req=0), the block SHALL drive FREEZE, and next state SHALL be MEMWAIT.
REQ-012 In RUN, hz_stall=1 SHALL drive LOADUSE; br_taken is ignored that cycle.
REQ-013 In RUN, br_taken=1 alone SHALL drive REDIRECT, and the block SHALL NOT produce a flush on the following cycle.
REQ-014 In RUN with no condition active, the block SHALL drive NORMAL.
REQ-015 In MEMWAIT with dmem_ready=0, the block SHALL drive FREEZE and stay in MEMWAIT; halt_req and resume SHALL be ignored.
REQ-016 In MEMWAIT with dmem_ready=1, outputs SHALL be evaluated exactly as RUN with the memory condition false (hz_stall/br_taken priority applies, halt_req ignored), and next state SHALL be RUN.
REQ-017 In HALT, the block SHALL drive FREEZE; resume=1 SHALL make the next state RUN, and resume is ignored in every other state.
REQ-018 dmem_ready=1 without dmem_req SHALL have no effect.

Reset
REQ-019 While rstn=0, the block SHALL hold state=BOOT, so outputs follow the BOOT pattern with halted=0, and all counters SHALL be 0.
REQ-020 Reset asserted mid-operation (any state, including MEMWAIT) SHALL take effect immediately and asynchronously; after release, the first edge SHALL execute BOOT.

Configuration
REQ-021 When macro PIPE_CTRL_PERF_CNT_EN is defined, the counters SHALL behave as follows, each wrapping modulo 2^32:
- cyc_cnt increments every cycle outside BOOT.
- stall_cnt increments on every cycle with PC_we=0 in RUN or MEMWAIT.
- flush_cnt increments on every cycle with IF_ID_flush=1 in RUN or MEMWAIT.
REQ-022 With PIPE_CTRL_PERF_CNT_EN defined, perf_clr=1 SHALL zero all three counters on the next edge, with clear taking priority over increment.
REQ-023 When PIPE_CTRL_PERF_CNT_EN is not defined, the counters SHALL be tied to 0 with no flops, perf_clr SHALL be ignored, and all other behaviour SHALL be identical.

Verification
REQ-024 The bench SHALL cover: release rstn -> one BOOT cycle (IF_ID_flush=ID_EX_flush=MEM_WB_flush=1, PC_we=0), then state=1 with NORMAL.
REQ-025 The bench SHALL cover: RUN, hz_stall=1 and br_taken=1 in the same cycle -> LOADUSE (PC_we=0, ID_EX_flush=1, IF_ID_flush=0); next cycle br_taken=1 alone -> REDIRECT.
REQ-026 The bench SHALL cover: dmem_req=1, dmem_ready=0 for 3 cycles, then 1 -> 3 FREEZE cycles in MEMWAIT, RUN afterwards, and stall_cnt +=3 when PIPE_CTRL_PERF_CNT_EN is defined.
REQ-027 The bench SHALL cover: halt_req=1 during MEMWAIT -> ignored; the same halt_req pulse in RUN -> HALT with halted=1; resume=1 -> RUN on the next cycle.
REQ-028 The bench SHALL cover: rstn=0 asserted in MEMWAIT -> outputs switch to BOOT immediately without a clock, and counters read 0.
REQ-029 The bench SHALL cover: with PIPE_CTRL_PERF_CNT_EN defined, cyc_cnt preset near wrap by running 2^32-1 cycles (or forced) -> wraps to 0; perf_clr=1 concurrent with an increment -> counters read 0.
